// File: rtl/vmem_rect_fill_pkg.sv
// Shared constants for the vmem rectangle-fill engine: register map, CTRL/STATUS bit
// positions, FSM encoding and default framebuffer geometry.
package vmem_rect_fill_pkg;

  localparam int FB_W_DEF = 240;
  localparam int FB_H_DEF = 240;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ORIGIN = 2'd1;
  localparam logic [1:0] REG_SIZE   = 2'd2;
  localparam logic [1:0] REG_COLOR  = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_CNT_LSB  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rect_addr_step.sv
// Raster x/y walker for the fill engine: latches (optionally clipped) geometry on load,
// steps row-major on advance and flags the last pixel. Clipping: VMEM_RECT_FILL_CLIP_EN.
module rect_addr_step
  import vmem_rect_fill_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [7:0]  x0_i,
  input  logic [7:0]  y0_i,
  input  logic [7:0]  w_i,
  input  logic [7:0]  h_i,
  output logic [15:0] addr_o,
  output logic        last_o,
  output logic        empty_o
);

  // The 9-bit datapath below only holds framebuffers up to 256 pixels per side.
  if (FB_W < 1 || FB_W > 256 || FB_H < 1 || FB_H > 256) begin : g_fb_range
    $error("rect_addr_step: FB_W and FB_H must be in 1..256");
  end

  logic [8:0] r_x0, r_x, r_y, r_xe, r_ye;
  logic [8:0] w_x0, w_y0, w_w, w_h, w_weff, w_heff;

  assign w_x0 = {1'b0, x0_i};
  assign w_y0 = {1'b0, y0_i};
  assign w_w  = {1'b0, w_i};
  assign w_h  = {1'b0, h_i};

`ifdef VMEM_RECT_FILL_CLIP_EN
  localparam logic [8:0] FB_W9 = 9'(FB_W);
  localparam logic [8:0] FB_H9 = 9'(FB_H);

  logic       w_off;
  logic [8:0] w_xroom, w_yroom;

  assign w_off   = (w_x0 >= FB_W9) || (w_y0 >= FB_H9);
  assign w_xroom = FB_W9 - w_x0;
  assign w_yroom = FB_H9 - w_y0;
  assign w_weff  = (w_w < w_xroom) ? w_w : w_xroom;
  assign w_heff  = (w_h < w_yroom) ? w_h : w_yroom;
  assign empty_o = w_off || (w_w == 9'd0) || (w_h == 9'd0);
`else
  assign w_weff  = w_w;
  assign w_heff  = w_h;
  assign empty_o = (w_w == 9'd0) || (w_h == 9'd0);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x0 <= '0;
      r_x  <= '0;
      r_y  <= '0;
      r_xe <= '0;
      r_ye <= '0;
    end else if (load_i) begin
      r_x0 <= w_x0;
      r_x  <= w_x0;
      r_y  <= w_y0;
      r_xe <= w_x0 + w_weff - 9'd1;
      r_ye <= w_y0 + w_heff - 9'd1;
    end else if (advance_i) begin
      if (r_x == r_xe) begin
        r_x <= r_x0;
        r_y <= r_y + 9'd1;
      end else begin
        r_x <= r_x + 9'd1;
      end
    end
  end

  // Unclipped builds wrap naturally by dropping bit 8 of the internal coordinates.
  assign addr_o = {r_y[7:0], r_x[7:0]};
  assign last_o = (r_x == r_xe) && (r_y == r_ye);

endmodule

// File: rtl/vmem_rect_fill.sv
// Rectangle-fill engine ahead of vmem: config/status window, IDLE/RUN FSM and the
// CPU-priority vmem write mux. Optional clipping: VMEM_RECT_FILL_CLIP_EN.
module vmem_rect_fill
  import vmem_rect_fill_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_waddr_i,
  input  logic [2:0]  cpu_wdata_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_waddr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);

  state_e      r_state, w_state_next;
  logic [15:0] r_origin, r_size, r_count;
  logic [2:0]  r_color;
  logic        r_done;
  logic [31:0] r_rdata, w_status;
  logic        w_ctrl_wr, w_start, w_abort, w_busy;
  logic        w_load, w_advance, w_eng_we, w_last, w_empty;
  logic [15:0] w_eng_addr;
  logic        w_unused;

  assign w_unused  = ^{cfg_addr_i[1:0], cfg_wdata_i[31:16]};
  assign w_busy    = (r_state == ST_RUN);
  assign w_ctrl_wr = cfg_we_i && (cfg_addr_i[3:2] == REG_CTRL);
  assign w_abort   = w_ctrl_wr && cfg_wdata_i[CTRL_ABORT_BIT];
  assign w_start   = w_ctrl_wr && cfg_wdata_i[CTRL_START_BIT] && !cfg_wdata_i[CTRL_ABORT_BIT];

  rect_addr_step #(
    .FB_W (FB_W),
    .FB_H (FB_H)
  ) u_step (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (w_load),
    .advance_i (w_advance),
    .x0_i      (r_origin[7:0]),
    .y0_i      (r_origin[15:8]),
    .w_i       (r_size[7:0]),
    .h_i       (r_size[15:8]),
    .addr_o    (w_eng_addr),
    .last_o    (w_last),
    .empty_o   (w_empty)
  );

  // The engine write depends only on registered state and cpu_we_i, so an ABORT
  // arriving in a RUN cycle still lets that cycle's pixel land and be counted.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_eng_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && !w_empty) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
        end
      end
      ST_RUN: begin
        w_eng_we  = !cpu_we_i;
        w_advance = !cpu_we_i;
        if (w_abort || (!cpu_we_i && w_last)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status                                   = '0;
    w_status[STAT_BUSY_BIT]                    = w_busy;
    w_status[STAT_DONE_BIT]                    = r_done;
    w_status[STAT_CNT_LSB +: 16]               = r_count;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_origin <= '0;
      r_size   <= '0;
      r_color  <= '0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (cfg_we_i && !w_busy) begin
        case (cfg_addr_i[3:2])
          REG_ORIGIN: r_origin <= cfg_wdata_i[15:0];
          REG_SIZE:   r_size   <= cfg_wdata_i[15:0];
          REG_COLOR:  r_color  <= cfg_wdata_i[2:0];
          default:    ;
        endcase
      end
      if (w_load) begin
        r_done  <= 1'b0;
        r_count <= '0;
      end else if (!w_busy && w_start) begin
        r_done  <= 1'b1;
        r_count <= '0;
      end else if (w_eng_we) begin
        r_count <= r_count + 16'd1;
        if (w_last && !w_abort) begin
          r_done <= 1'b1;
        end
      end
      r_rdata <= w_status;
    end
  end

  always_comb begin
    vmem_we_o    = 1'b0;
    vmem_waddr_o = '0;
    vmem_wdata_o = '0;
    if (cpu_we_i) begin
      vmem_we_o    = 1'b1;
      vmem_waddr_o = cpu_waddr_i;
      vmem_wdata_o = cpu_wdata_i;
    end else if (w_busy) begin
      vmem_we_o    = 1'b1;
      vmem_waddr_o = w_eng_addr;
      vmem_wdata_o = r_color;
    end
  end

  assign cfg_rdata_o = r_rdata;
  assign busy_o      = w_busy;

endmodule
